// File: rtl/shift_reg_ctrl.sv
// Flow-control sequencer for a TAPE-stage shift_reg delay line: per-stage valid shadow, back-pressure, drain, flush.
// Optional stall statistics output o_stall_cnt when SHIFT_REG_CTRL_STATS_EN is defined.
module shift_reg_ctrl #(
    parameter int TAPE  = 1,
    parameter int CNT_W = $clog2(TAPE + 1)
) (
    input  logic             i_clk,
    input  logic             i_srst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_sr_en,
    input  logic             i_drain,
    input  logic             i_flush,
    output logic             o_drain_done,
    output logic             o_busy,
`ifdef SHIFT_REG_CTRL_STATS_EN
    output logic [15:0]      o_stall_cnt,
`endif
    output logic [CNT_W-1:0] o_occ
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FLUSH} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [TAPE-1:0]   vld;
    logic [CNT_W-1:0]  occ;
    logic [CNT_W-1:0]  occ_nxt;
    logic              advance;
    logic              accept;
    logic              consume;
    logic              drain_done_q;
    logic              drain_done_nxt;

    // The output stage is masked during FLUSH so nothing can be consumed while the line is being discarded.
    assign o_out_valid = vld[TAPE-1] & (state != FLUSH);
    assign advance     = ~o_out_valid | i_out_ready;
    assign o_sr_en     = advance & (state != FLUSH);
    assign o_in_ready  = advance & ((state == IDLE) | (state == RUN)) & ~i_flush & ~i_drain;
    assign accept      = i_in_valid & o_in_ready;
    assign consume     = o_out_valid & i_out_ready;

    assign o_busy       = (state != IDLE);
    assign o_occ        = occ;
    assign o_drain_done = drain_done_q;

    always_comb begin
        occ_nxt = occ;
        case ({accept, consume})
            2'b10:   occ_nxt = occ + 1'b1;
            2'b01:   occ_nxt = occ - 1'b1;
            default: occ_nxt = occ;
        endcase
    end

    always_comb begin
        state_nxt      = state;
        drain_done_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (i_flush) begin
                    state_nxt = FLUSH;
                end else if (i_drain) begin
                    drain_done_nxt = 1'b1;
                end else if (accept) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (i_flush) begin
                    state_nxt = FLUSH;
                end else if (i_drain) begin
                    // A drain request that finds the line already emptying this cycle completes at once.
                    if (occ_nxt == '0) begin
                        state_nxt      = IDLE;
                        drain_done_nxt = 1'b1;
                    end else begin
                        state_nxt = DRAIN;
                    end
                end else if ((occ_nxt == '0) && !accept) begin
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (i_flush) begin
                    state_nxt = FLUSH;
                end else if (occ_nxt == '0) begin
                    state_nxt      = IDLE;
                    drain_done_nxt = 1'b1;
                end
            end
            FLUSH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state        <= IDLE;
            vld          <= '0;
            occ          <= '0;
            drain_done_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            drain_done_q <= drain_done_nxt;
            if (state == FLUSH) begin
                vld <= '0;
                occ <= '0;
            end else begin
                occ <= occ_nxt;
                if (advance) begin
                    for (int i = TAPE - 1; i > 0; i--) begin
                        vld[i] <= vld[i-1];
                    end
                    vld[0] <= accept;
                end
            end
        end
    end

`ifdef SHIFT_REG_CTRL_STATS_EN
    logic [15:0] stall_cnt;

    // Saturating count of cycles where downstream holds off a valid word.
    always_ff @(posedge i_clk) begin
        if (i_srst || i_flush) begin
            stall_cnt <= '0;
        end else if (o_out_valid && !i_out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign o_stall_cnt = stall_cnt;
`endif

endmodule
